// File: rtl/quad_solver_ctrl.sv
// Quadratic-equation controller: captures a, b, c, forms delta = b*b - 4ac,
// extracts floor(sqrt(delta)) one bit per cycle and emits the root numerators
// (-b +/- s), the denominator 2a and a root classification.
module quad_solver_ctrl #(
  parameter int unsigned W  = 8,
  parameter int unsigned DW = 2 * W + 2,
  parameter int unsigned SW = W + 1,
  parameter int unsigned NW = W + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic signed [W-1:0]  a,
  input  logic signed [W-1:0]  b,
  input  logic signed [W-1:0]  c,
  output logic                 busy,
  output logic                 done,
  output logic signed [DW-1:0] delta_out,
  output logic        [SW-1:0] sqrt_out,
  output logic signed [NW-1:0] num1,
  output logic signed [NW-1:0] num2,
  output logic signed [W:0]    den,
  output logic        [1:0]    status,
  output logic                 exact
);

  localparam int unsigned CW = $clog2(SW);

  typedef enum logic [2:0] {StIdle, StDelta, StSqrt, StRoots, StDone} state_e;

  state_e               state_q;
  logic signed [W-1:0]  a_q, b_q, c_q;
  logic signed [DW-1:0] delta_q;
  logic [2*SW-1:0]      rad_q;   // radicand, consumed two bits per cycle from the top
  logic [SW+1:0]        rem_q;
  logic [SW-1:0]        root_q;
  logic [CW-1:0]        cnt_q;

  logic signed [DW-1:0] a_x, b_x, c_x, delta_c;
  logic [SW+1:0]        rem_sh, trial, rem_nxt;
  logic                 take;
  logic [SW-1:0]        root_nxt;
  logic signed [NW-1:0] neg_b, s_x, num1_c, num2_c;
  logic signed [W:0]    den_c;

  // Delta in full DW-bit signed arithmetic; cannot overflow for W-bit inputs
  always_comb begin
    a_x     = DW'(a_q);
    b_x     = DW'(b_q);
    c_x     = DW'(c_q);
    delta_c = (b_x * b_x) - ((a_x * c_x) <<< 2);
  end

  // One restoring sqrt step: bring down two radicand bits, trial-subtract 4r+1
  always_comb begin
    rem_sh   = {rem_q[SW-1:0], rad_q[2*SW-1 -: 2]};
    trial    = {root_q, 2'b01};
    take     = (rem_sh >= trial);
    rem_nxt  = take ? (rem_sh - trial) : rem_sh;
    root_nxt = {root_q[SW-2:0], take};
  end

  // Root numerators; -b is widened first so b = -2^(W-1) does not wrap
  always_comb begin
    neg_b  = -(NW'(b_q));
    s_x    = NW'(root_q);
    num1_c = neg_b + s_x;
    num2_c = neg_b - s_x;
    den_c  = {a_q, 1'b0};
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

  // Controller FSM with working registers and held result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      delta_q   <= '0;
      rad_q     <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      cnt_q     <= '0;
      delta_out <= '0;
      sqrt_out  <= '0;
      num1      <= '0;
      num2      <= '0;
      den       <= '0;
      status    <= 2'b00;
      exact     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            c_q     <= c;
            state_q <= StDelta;
          end
        end
        StDelta: begin
          delta_q <= delta_c;
          rad_q   <= delta_c;
          rem_q   <= '0;
          root_q  <= '0;
          cnt_q   <= CW'(SW - 1);
          if ((a_q == '0) || (delta_c < 0)) begin
            // No real quadratic roots to extract: publish immediately
            delta_out <= delta_c;
            sqrt_out  <= '0;
            num1      <= '0;
            num2      <= '0;
            den       <= den_c;
            status    <= (a_q == '0) ? 2'b11 : 2'b10;
            exact     <= (delta_c == '0);
            state_q   <= StDone;
          end else begin
            state_q <= StSqrt;
          end
        end
        StSqrt: begin
          rem_q  <= rem_nxt;
          root_q <= root_nxt;
          rad_q  <= {rad_q[2*SW-3:0], 2'b00};
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q <= StRoots;
          end
        end
        StRoots: begin
          delta_out <= delta_q;
          sqrt_out  <= root_q;
          num1      <= num1_c;
          num2      <= num2_c;
          den       <= den_c;
          status    <= (delta_q == '0) ? 2'b01 : 2'b00;
          exact     <= (rem_q == '0);  // zero final remainder <=> perfect square
          state_q   <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quad_solver_ctrl.sv
// Scoreboard bench for quad_solver_ctrl: the stimulus side pushes expected
// results from an arithmetic reference model, the monitor pops on every done.
module tb_quad_solver_ctrl;

  localparam int W  = 8;
  localparam int DW = 2 * W + 2;
  localparam int SW = W + 1;
  localparam int NW = W + 2;
  localparam int LAT_NORMAL = W + 4;
  localparam int LAT_EARLY  = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic signed [W-1:0]  a = '0, b = '0, c = '0;
  logic                 busy, done;
  logic signed [DW-1:0] delta_out;
  logic        [SW-1:0] sqrt_out;
  logic signed [NW-1:0] num1, num2;
  logic signed [W:0]    den;
  logic        [1:0]    status;
  logic                 exact;

  quad_solver_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .c         (c),
    .busy      (busy),
    .done      (done),
    .delta_out (delta_out),
    .sqrt_out  (sqrt_out),
    .num1      (num1),
    .num2      (num2),
    .den       (den),
    .status    (status),
    .exact     (exact)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int done_cyc;
    int delta;
    int sq;
    int n1;
    int n2;
    int den;
    int status;
    int exact;
    bit early;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
  endtask

  // Reference: solve the quadratic directly with integer arithmetic
  task automatic model(input int ia, input int ib, input int ic, input int t, output exp_t e);
    int d, s;
    d = ib * ib - 4 * ia * ic;
    s = 0;
    e.delta = d;
    e.den   = 2 * ia;
    if (ia == 0 || d < 0) begin
      e.early  = 1'b1;
      e.status = (ia == 0) ? 3 : 2;
      e.sq     = 0;
      e.n1     = 0;
      e.n2     = 0;
    end else begin
      while ((s + 1) * (s + 1) <= d) s++;
      e.early  = 1'b0;
      e.status = (d == 0) ? 1 : 0;
      e.sq     = s;
      e.n1     = -ib + s;
      e.n2     = -ib - s;
    end
    e.exact    = (e.sq * e.sq == d) ? 1 : 0;
    e.done_cyc = t + (e.early ? LAT_EARLY : LAT_NORMAL);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: got done, expected none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.done_cyc);
        chk("delta", int'(delta_out), e.delta);
        chk("sqrt", int'(sqrt_out), e.sq);
        chk("num1", int'(num1), e.n1);
        chk("num2", int'(num2), e.n2);
        chk("status", int'(status), e.status);
        chk("exact", int'(exact), e.exact);
        if (!e.early) chk("den", int'(den), e.den);
      end
    end
  end

  // Single operation: pulse start for one cycle, scramble inputs, time busy
  task automatic op(input int ia, input int ib, input int ic);
    exp_t e;
    int nb;
    a = W'(ia);
    b = W'(ib);
    c = W'(ic);
    start = 1'b1;
    model(ia, ib, ic, cyc, e);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    c = W'($urandom);
    nb = 0;
    while (busy && nb < 40) begin
      nb++;
      @(negedge clk);
    end
    chk("busy_cycles", nb, e.early ? LAT_EARLY : LAT_NORMAL);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_delta"}, int'(delta_out), 0);
    chk({tag, "_sqrt"}, int'(sqrt_out), 0);
    chk({tag, "_num1"}, int'(num1), 0);
    chk({tag, "_num2"}, int'(num2), 0);
    chk({tag, "_den"}, int'(den), 0);
    chk({tag, "_status"}, int'(status), 0);
    chk({tag, "_exact"}, int'(exact), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   t, rel, wait_n;

    repeat (3) @(negedge clk);
    chk_cleared("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    op(1, -5, 6);
    op(1, 2, 1);
    op(1, 0, 1);
    op(0, 3, 1);
    op(-128, -128, 127);

    // start held high: one accept per operation, next accept right after done
    a = 8'sd1; b = -8'sd5; c = 8'sd6;
    start = 1'b1;
    t = cyc;
    for (int k = 0; k < 3; k++) begin
      model(1, -5, 6, t + k * (LAT_NORMAL + 1), e);
      sb.push_back(e);
    end
    for (int k = 1; k <= 3 * (LAT_NORMAL + 1) - 1; k++) begin
      @(negedge clk);
      rel = (cyc - t) % (LAT_NORMAL + 1);
      if (rel == 3) begin
        a = 8'sd7; b = 8'sd9; c = -8'sd3;
      end else if (rel == 10) begin
        a = 8'sd1; b = -8'sd5; c = 8'sd6;
      end
    end
    start = 1'b0;
    @(negedge clk);
    chk("held_start_idle", int'(busy), 0);

    // Reset in the middle of a normal run
    a = 8'sd1; b = -8'sd5; c = 8'sd6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_cleared("midrst");
    repeat (15) @(negedge clk);
    chk("midrst_stays_idle", int'(busy), 0);
    op(1, -5, 6);

    // Randomized operations, with a forced a==0 every so often
    for (int i = 0; i < 60; i++) begin
      int ra, rb, rc;
      ra = $urandom_range(0, 255) - 128;
      rb = $urandom_range(0, 255) - 128;
      rc = $urandom_range(0, 255) - 128;
      if (i % 7 == 3) ra = 0;
      if (i % 11 == 5) rc = (rb * rb) / (4 * ((ra == 0) ? 1 : ra));
      if (rc > 127) rc = 127;
      if (rc < -128) rc = -128;
      op(ra, rb, rc);
    end

    wait_n = 0;
    while (sb.size() != 0 && wait_n < 40) begin
      wait_n++;
      @(negedge clk);
    end
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/quad_solver_ctrl.md
Name: quad_solver_ctrl

Overview:
Sequential controller for the quadratic-equation datapath. It accepts signed coefficients a, b, c on a start/done handshake and computes delta = b*b - 4*a*c. It then runs an exact iterative integer square root, one result bit per cycle, in place of a table lookup. It classifies the roots and emits the root numerators (-b ± floor(sqrt(delta))) and the denominator 2a for a downstream divider/display stage.

Parameters:
W, 8, coefficient width (signed a, b, c)
DW, 2*W+2, delta width (signed, derived; do not override)
SW, W+1, sqrt result width (unsigned, derived)
NW, W+2, root numerator width (signed, derived)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  request; sampled only in IDLE
a  in  W  signed coefficient a
b  in  W  signed coefficient b
c  in  W  signed coefficient c
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse; result outputs valid
delta_out  out  DW  signed delta
sqrt_out  out  SW  floor(sqrt(delta)); 0 if delta<0 or a==0
num1  out  NW  signed -b + sqrt_out
num2  out  NW  signed -b - sqrt_out
den  out  W+1  signed 2*a
status  out  2  00 two distinct real roots, 01 double root, 10 complex (delta<0), 11 degenerate (a==0)
exact  out  1  sqrt_out*sqrt_out == delta_out

Behaviour:
- One clock; reset is synchronous and active-high. clk/rst as named above.
- Reset: state IDLE; busy=0, done=0; all result outputs 0; exact=0. Reset asserted mid-operation aborts the computation: no done pulse, outputs cleared.
- States: IDLE, DELTA, SQRT, ROOTS, DONE.
- Cycle T, IDLE with start=1: capture a, b, c into internal registers, go to DELTA. start=0 keeps IDLE.
- DELTA (T+1): register delta using full-width signed arithmetic. No overflow at DW bits: max 2^(2W-2) + 2^(2W).
  - a==0: go to DONE with status=11, sqrt=0.
  - else delta<0: go to DONE with status=10, sqrt=0.
  - else: go to SQRT, load iteration counter = SW-1.
- SQRT (T+2 .. T+2+W, exactly SW cycles):
  - Restoring bit-serial integer sqrt. Each cycle resolves one result bit, MSB first; the remainder is updated with a trial subtract.
  - Counter decrements each cycle; leaves for ROOTS when the counter is 0.
- ROOTS (T+W+3): compute num1 = -b + s and num2 = -b - s, sign-extended to NW. Compute den = 2a, exact, and status (01 if delta==0, else 00).
- DONE (T+W+4 normal, T+2 early exit):
  - done=1 for exactly one cycle; all outputs already updated in this cycle.
  - Next state IDLE.
- Outputs hold their values after DONE until the next DONE or reset.
- start while busy (including the DONE cycle) is ignored and not queued. Input changes after capture have no effect.
- Back-to-back: the earliest new accept is the cycle after DONE.
- -b with b = -2^(W-1) must use a W+1-bit intermediate, not wrap.
- W=8 latency: start to done = 12 cycles normal, 2 cycles early exit.

Test Plan:
- a=1, b=-5, c=6, start at T -> done at T+12; delta=1, sqrt=1, num1=6, num2=4, den=2, status=00, exact=1; busy high T+1..T+12.
- a=1, b=2, c=1 -> delta=0, sqrt=0, num1=num2=-2, den=2, status=01, exact=1, done at T+12.
- a=1, b=0, c=1 -> done at T+2; delta=-4, sqrt=0, status=10, num1=num2=0. Then a=0, b=3, c=1 -> done at T+2, status=11.
- a=-128, b=-128, c=127 -> delta=81408, sqrt=285, exact=0, num1=413, num2=-157, den=-256, status=00.
- start held high continuously with a=1, b=-5, c=6 -> a single accept per operation; next accept the cycle after done (done every 13 cycles); a coefficient change during busy does not affect the results.
- rst asserted at T+5 of a normal run -> next cycle IDLE, busy=0, outputs 0, no done; a subsequent start completes normally.
